// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster timing generator for VGA-style displays.
// Walks a (column, line) position across an HTOT x VTOT raster at the pixel
// rate given by i_pixEn. For each position it produces registered hSync,
// vSync, data-enable, line-start and frame-start flags.
// Optional feature: define VGA_TIMING_GEN_FRAMECNT_EN to add the o_frameCnt
// port, a free-running frame counter modulo 2^FCW.
// All outputs come straight from flops. Sync/de flags are computed from the
// counter values being loaded, so they always describe the pixel currently
// presented on o_hCnt/o_vCnt.

module vga_timing_gen #(
  parameter int   HACT = 640,
  parameter int   HFP  = 16,
  parameter int   HSW  = 96,
  parameter int   HBP  = 48,
  parameter int   VACT = 480,
  parameter int   VFP  = 10,
  parameter int   VSW  = 2,
  parameter int   VBP  = 33,
  parameter logic HPOL = 1'b0,
  parameter logic VPOL = 1'b0,
  parameter int   HW   = 11,
  parameter int   VW   = 10,
  parameter int   FCW  = 8
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          i_pixEn,
  input  logic          i_restart,
  output logic [HW-1:0] o_hCnt,
  output logic [VW-1:0] o_vCnt,
  output logic          o_hSync,
  output logic          o_vSync,
  output logic          o_de,
  output logic          o_lineStart,
  output logic          o_frameStart
`ifdef VGA_TIMING_GEN_FRAMECNT_EN
  ,
  output logic [FCW-1:0] o_frameCnt
`endif
);

  localparam int HTOT = HACT + HFP + HSW + HBP;
  localparam int VTOT = VACT + VFP + VSW + VBP;

  // Region boundaries as integers so a sync window ending exactly at
  // 2^HW (zero back porch) is still compared correctly.
  localparam int HS_BEG = HACT + HFP;
  localparam int HS_END = HACT + HFP + HSW;
  localparam int VS_BEG = VACT + VFP;
  localparam int VS_END = VACT + VFP + VSW;

  // hSync level for a given column.
  function automatic logic f_hsync(input logic [HW-1:0] h);
    int hi;
    hi = int'(h);
    return ((hi >= HS_BEG) && (hi < HS_END)) ? HPOL : ~HPOL;
  endfunction

  // vSync level for a given line.
  function automatic logic f_vsync(input logic [VW-1:0] v);
    int vi;
    vi = int'(v);
    return ((vi >= VS_BEG) && (vi < VS_END)) ? VPOL : ~VPOL;
  endfunction

  // Active-video flag for a given position.
  function automatic logic f_de(input logic [HW-1:0] h, input logic [VW-1:0] v);
    return (int'(h) < HACT) && (int'(v) < VACT);
  endfunction

  logic [HW-1:0] r_hCnt;
  logic [VW-1:0] r_vCnt;
  logic          r_hSync;
  logic          r_vSync;
  logic          r_de;
  logic          r_lineStart;
  logic          r_frameStart;

  logic          w_hLast;
  logic          w_vLast;
  logic [HW-1:0] w_hNext;
  logic [VW-1:0] w_vNext;
  logic          w_lineWrap;
  logic          w_frameWrap;
  logic          w_frameLoad;

  // End-of-line / end-of-frame detection and the position after one pixel.
  assign w_hLast     = (int'(r_hCnt) == HTOT - 1);
  assign w_vLast     = (int'(r_vCnt) == VTOT - 1);
  assign w_hNext     = w_hLast ? '0 : r_hCnt + 1'b1;
  assign w_vNext     = w_hLast ? (w_vLast ? '0 : r_vCnt + 1'b1) : r_vCnt;
  assign w_lineWrap  = i_pixEn & w_hLast;
  assign w_frameWrap = w_lineWrap & w_vLast;
  // A frame starts either by wrapping naturally or by an explicit restart.
  assign w_frameLoad = i_restart | w_frameWrap;

  // Raster position: restart wins over counting; pixEn gates advancing.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_hCnt <= '0;
      r_vCnt <= '0;
    end else if (i_restart) begin
      r_hCnt <= '0;
      r_vCnt <= '0;
    end else if (i_pixEn) begin
      r_hCnt <= w_hNext;
      r_vCnt <= w_vNext;
    end
  end

  // Sync and data-enable flags track the position being loaded above.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_hSync <= ~HPOL;
      r_vSync <= ~VPOL;
      r_de    <= 1'b1;
    end else if (i_restart) begin
      r_hSync <= ~HPOL;
      r_vSync <= ~VPOL;
      r_de    <= 1'b1;
    end else if (i_pixEn) begin
      r_hSync <= f_hsync(w_hNext);
      // w_vNext only differs from r_vCnt when the line wraps, so vSync
      // can only change on the edge where hCnt returns to 0.
      r_vSync <= f_vsync(w_vNext);
      r_de    <= f_de(w_hNext, w_vNext);
    end
  end

  // Single-clock strobes marking the first pixel of a line / frame.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_lineStart  <= 1'b0;
      r_frameStart <= 1'b0;
    end else begin
      r_lineStart  <= i_restart | w_lineWrap;
      r_frameStart <= w_frameLoad;
    end
  end

`ifdef VGA_TIMING_GEN_FRAMECNT_EN
  logic [FCW-1:0] r_frameCnt;

  // Frame counter steps on the same edge that raises o_frameStart.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_frameCnt <= '0;
    end else if (w_frameLoad) begin
      r_frameCnt <= r_frameCnt + 1'b1;
    end
  end

  assign o_frameCnt = r_frameCnt;
`else
  // FCW only sizes o_frameCnt, which does not exist in this build.
  localparam int FCW_unused = FCW;
`endif

  assign o_hCnt       = r_hCnt;
  assign o_vCnt       = r_vCnt;
  assign o_hSync      = r_hSync;
  assign o_vSync      = r_vSync;
  assign o_de         = r_de;
  assign o_lineStart  = r_lineStart;
  assign o_frameStart = r_frameStart;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: scoreboard bench for vga_timing_gen.
// Two instances share the stimulus: one with the default 640x480 timing and
// one with a tiny 12x7 raster (inverted polarities) so whole frames fit in a
// short run. A reference model predicts every output per clock.

module tb_vga_timing_gen;

  typedef struct {
    int hact, hfp, hsw, hbp, vact, vfp, vsw, vbp;
    bit hpol, vpol;
    int fcmod;
  } cfg_t;

  typedef struct {
    int h, v;
    bit hs, vs, de, ls, fs;
    int fc;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic pixEn = 1'b0;
  logic restart = 1'b0;

  logic [10:0] o0_h;
  logic [9:0]  o0_v;
  logic        o0_hs, o0_vs, o0_de, o0_ls, o0_fs;
  logic [3:0]  o1_h;
  logic [2:0]  o1_v;
  logic        o1_hs, o1_vs, o1_de, o1_ls, o1_fs;
`ifdef VGA_TIMING_GEN_FRAMECNT_EN
  logic [7:0]  o0_fc;
  logic [1:0]  o1_fc;
`endif

  always #5 clock = ~clock;

  vga_timing_gen u_dflt (
    .clock(clock), .reset(reset), .i_pixEn(pixEn), .i_restart(restart),
    .o_hCnt(o0_h), .o_vCnt(o0_v), .o_hSync(o0_hs), .o_vSync(o0_vs),
    .o_de(o0_de), .o_lineStart(o0_ls), .o_frameStart(o0_fs)
`ifdef VGA_TIMING_GEN_FRAMECNT_EN
    , .o_frameCnt(o0_fc)
`endif
  );

  vga_timing_gen #(
    .HACT(8), .HFP(1), .HSW(2), .HBP(1), .VACT(4), .VFP(1), .VSW(1), .VBP(1),
    .HPOL(1'b1), .VPOL(1'b1), .HW(4), .VW(3), .FCW(2)
  ) u_small (
    .clock(clock), .reset(reset), .i_pixEn(pixEn), .i_restart(restart),
    .o_hCnt(o1_h), .o_vCnt(o1_v), .o_hSync(o1_hs), .o_vSync(o1_vs),
    .o_de(o1_de), .o_lineStart(o1_ls), .o_frameStart(o1_fs)
`ifdef VGA_TIMING_GEN_FRAMECNT_EN
    , .o_frameCnt(o1_fc)
`endif
  );

  cfg_t cfg[2];
  int   mh[2], mv[2], mfc[2];
  bit   mls[2], mfs[2];
  exp_t q0[$];
  exp_t q1[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;

  task automatic chk(input string tag, input logic [31:0] got, input int want);
    n_vec++;
    if (got !== 32'(want)) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  function automatic exp_t derive(input cfg_t c, input int k);
    exp_t e;
    e.h  = mh[k];
    e.v  = mv[k];
    e.hs = (mh[k] >= c.hact + c.hfp && mh[k] < c.hact + c.hfp + c.hsw) ? c.hpol : !c.hpol;
    e.vs = (mv[k] >= c.vact + c.vfp && mv[k] < c.vact + c.vfp + c.vsw) ? c.vpol : !c.vpol;
    e.de = (mh[k] < c.hact) && (mv[k] < c.vact);
    e.ls = mls[k];
    e.fs = mfs[k];
    e.fc = mfc[k];
    return e;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      mh[k] = 0; mv[k] = 0; mfc[k] = 0; mls[k] = 0; mfs[k] = 0;
    end
  endtask

  task automatic model_step(input bit pe, input bit rs);
    for (int k = 0; k < 2; k++) begin
      int htot, vtot;
      htot = cfg[k].hact + cfg[k].hfp + cfg[k].hsw + cfg[k].hbp;
      vtot = cfg[k].vact + cfg[k].vfp + cfg[k].vsw + cfg[k].vbp;
      mls[k] = 0;
      mfs[k] = 0;
      if (rs) begin
        mh[k] = 0; mv[k] = 0; mls[k] = 1; mfs[k] = 1;
        mfc[k] = (mfc[k] + 1) % cfg[k].fcmod;
      end else if (pe) begin
        mh[k]++;
        if (mh[k] == htot) begin
          mh[k] = 0; mls[k] = 1; mv[k]++;
          if (mv[k] == vtot) begin
            mv[k] = 0; mfs[k] = 1;
            mfc[k] = (mfc[k] + 1) % cfg[k].fcmod;
          end
        end
      end
    end
  endtask

  task automatic check_all(input string who, input exp_t e, input logic [31:0] h,
                           input logic [31:0] v, input logic hs, input logic vs,
                           input logic de, input logic ls, input logic fs,
                           input logic [31:0] fc);
    chk({who, ".hCnt"}, h, e.h);
    chk({who, ".vCnt"}, v, e.v);
    chk({who, ".hSync"}, 32'(hs), int'(e.hs));
    chk({who, ".vSync"}, 32'(vs), int'(e.vs));
    chk({who, ".de"}, 32'(de), int'(e.de));
    chk({who, ".lineStart"}, 32'(ls), int'(e.ls));
    chk({who, ".frameStart"}, 32'(fs), int'(e.fs));
`ifdef VGA_TIMING_GEN_FRAMECNT_EN
    chk({who, ".frameCnt"}, fc, e.fc);
`endif
  endtask

  function automatic logic [31:0] fc0();
`ifdef VGA_TIMING_GEN_FRAMECNT_EN
    return 32'(o0_fc);
`else
    return 32'd0;
`endif
  endfunction

  function automatic logic [31:0] fc1();
`ifdef VGA_TIMING_GEN_FRAMECNT_EN
    return 32'(o1_fc);
`else
    return 32'd0;
`endif
  endfunction

  task automatic compare_now(input exp_t e0, input exp_t e1);
    check_all("dflt", e0, 32'(o0_h), 32'(o0_v), o0_hs, o0_vs, o0_de, o0_ls, o0_fs, fc0());
    check_all("small", e1, 32'(o1_h), 32'(o1_v), o1_hs, o1_vs, o1_de, o1_ls, o1_fs, fc1());
  endtask

  // Drive one clock of stimulus, predict, then compare after the edge.
  task automatic step(input bit pe, input bit rs);
    pixEn   = pe;
    restart = rs;
    model_step(pe, rs);
    q0.push_back(derive(cfg[0], 0));
    q1.push_back(derive(cfg[1], 1));
    @(posedge clock);
    @(negedge clock);
    cyc++;
    compare_now(q0.pop_front(), q1.pop_front());
  endtask

  task automatic async_reset_check();
    @(negedge clock);
    pixEn = 1'b1;
    reset = 1'b1;
    #1;
    model_reset();
    compare_now(derive(cfg[0], 0), derive(cfg[1], 1));
    @(negedge clock);
    reset = 1'b0;
  endtask

  int last_ls0, last_fs1;

  initial begin
    cfg[0] = '{640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0, 256};
    cfg[1] = '{8, 1, 2, 1, 4, 1, 1, 1, 1'b1, 1'b1, 4};
    model_reset();

    #2 reset = 1'b1;
    @(negedge clock);
    compare_now(derive(cfg[0], 0), derive(cfg[1], 1));
    reset = 1'b0;

    // Free-running pixel clock: line period 800, small frame period 84.
    last_ls0 = -1; last_fs1 = -1;
    for (int i = 0; i < 1700; i++) begin
      step(1'b1, 1'b0);
      if (o0_ls) begin
        if (last_ls0 >= 0) chk("dflt.linePeriod", 32'(cyc - last_ls0), 800);
        last_ls0 = cyc;
      end
      if (o1_fs) begin
        if (last_fs1 >= 0) chk("small.framePeriod", 32'(cyc - last_fs1), 84);
        last_fs1 = cyc;
      end
    end

    // Pixel enable one clock in four: line period 3200 clocks.
    last_ls0 = -1;
    for (int i = 0; i < 3 * 3200 + 8; i++) begin
      step((i % 4) == 0, 1'b0);
      if (o0_ls) begin
        if (last_ls0 >= 0) chk("dflt.linePeriod4", 32'(cyc - last_ls0), 3200);
        last_ls0 = cyc;
      end
    end

    // Restart with pixEn low once the default instance reaches column 300.
    for (int i = 0; i < 900 && mh[0] != 300; i++) step(1'b1, 1'b0);
    chk("dflt.reachCol300", 32'(o0_h), 300);
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);

    // Random enables with occasional restarts.
    for (int i = 0; i < 5000; i++)
      step(1'(($urandom_range(0, 3)) != 0), ($urandom_range(0, 249) == 0));

    // Mid-frame reset, then the first enabled pixel goes to column 1.
    async_reset_check();
    step(1'b1, 1'b0);
    for (int i = 0; i < 400; i++) step(1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameter HACT, 640, active pixels per line.
REQ-002 Parameter HFP, 16, horizontal front porch in pixels.
REQ-003 Parameter HSW, 96, horizontal sync width in pixels.
REQ-004 Parameter HBP, 48, horizontal back porch in pixels; HTOT = HACT+HFP+HSW+HBP.
REQ-005 Parameter VACT, 480, active lines per frame.
REQ-006 Parameter VFP, 10, vertical front porch in lines.
REQ-007 Parameter VSW, 2, vertical sync width in lines.
REQ-008 Parameter VBP, 33, vertical back porch in lines; VTOT = VACT+VFP+VSW+VBP.
REQ-009 Parameter HPOL, 0, hSync active level; VPOL, 0, vSync active level.
REQ-010 Parameter HW, 11, hCnt width; VW, 10, vCnt width; FCW, 8, frameCnt width; HTOT <= 2^HW and VTOT <= 2^VW SHALL hold.
REQ-011 Ports: clock input 1 system clock; reset input 1 asynchronous active-high reset.
REQ-012 Ports: pixEn input 1 pixel-rate clock enable; restart input 1 synchronous restart to pixel (0,0).
REQ-013 Ports: hCnt output HW current pixel column; vCnt output VW current line.
REQ-014 Ports: hSync output 1; vSync output 1; de output 1 active-video flag.
REQ-015 Ports: lineStart output 1 single-clock strobe; frameStart output 1 single-clock strobe.
REQ-016 Port frameCnt output FCW frame counter, present only under VGA_TIMING_GEN_FRAMECNT_EN.

Function
REQ-017 All outputs SHALL be registered; no combinational path from input to output.
REQ-018 hCnt SHALL advance only in cycles with pixEn=1: hCnt==HTOT-1 -> 0, else +1.
REQ-019 vCnt SHALL advance only when pixEn=1 and hCnt==HTOT-1: vCnt==VTOT-1 -> 0, else +1.
REQ-020 hSync, vSync and de SHALL describe the pixel currently held in (hCnt,vCnt), i.e. they update in the same clock edge as the counters (zero relative latency).
REQ-021 hSync SHALL equal HPOL iff HACT+HFP <= hCnt < HACT+HFP+HSW, else ~HPOL.
REQ-022 vSync SHALL equal VPOL iff VACT+VFP <= vCnt < VACT+VFP+VSW, else ~VPOL, changing only on the edge where hCnt becomes 0.
REQ-023 de SHALL be 1 iff hCnt < HACT and vCnt < VACT.
REQ-024 lineStart SHALL be 1 for exactly one clock, on the edge where hCnt wraps to 0 (pixEn-qualified), else 0.
REQ-025 frameStart SHALL be 1 for exactly one clock, on the edge where both counters wrap to 0, else 0; lineStart also 1 that cycle.
REQ-026 With pixEn=0, counters, hSync, vSync, de SHALL hold; strobes SHALL be 0.
REQ-027 restart=1 SHALL, regardless of pixEn, load hCnt=0, vCnt=0, de=1, hSync=~HPOL, vSync=~VPOL, lineStart=1, frameStart=1; restart has priority over counting.
REQ-028 pixEn permanently 1 SHALL give frame period HTOT*VTOT clocks (default 420000).

Reset
REQ-029 On reset: hCnt=0, vCnt=0, hSync=~HPOL, vSync=~VPOL, de=1, lineStart=0, frameStart=0, frameCnt=0.
REQ-030 Reset asserted mid-frame SHALL abort immediately; first pixEn cycle after release advances hCnt to 1 without a strobe.

Configuration
REQ-031 Macro VGA_TIMING_GEN_FRAMECNT_EN defined: frameCnt port exists, increments modulo 2^FCW on each clock frameStart is registered 1 (including restart), reset 0.
REQ-032 Macro undefined: frameCnt port and its logic SHALL be absent; all other behaviour identical.

Verification
REQ-033 Defaults, pixEn=1 after reset: hSync low hCnt 656..751, de falls at hCnt=640, lineStart every 800 clocks, frameStart every 420000 clocks.
REQ-034 Defaults: vSync low for vCnt 490..491, asserted exactly at hCnt=0 of line 490, deasserted at hCnt=0 of line 492; de=0 for all of vCnt 480..524.
REQ-035 pixEn toggled 1-of-4 clocks: counters advance once per 4 clocks, strobes 1 clock wide, line period 3200 clocks.
REQ-036 restart pulsed at hCnt=300,vCnt=200 with pixEn=0: next cycle hCnt=0, vCnt=0, de=1, lineStart=frameStart=1.
REQ-037 HPOL=1, VPOL=1, HACT=8,HFP=1,HSW=2,HBP=1,VACT=4,VFP=1,VSW=1,VBP=1: hSync high hCnt 9..10, vSync high vCnt 5, frame period 84 clocks.
REQ-038 Macro defined, FCW=2: after 5 frameStart strobes frameCnt=1; reset mid-frame returns frameCnt=0.
